// File: rtl/bf_bus_ctrl_if.sv
// Data-side bus bundle between the Brainfuck CPU, data RAM, TX/RX byte streams and debug port.
// Pure wiring: no storage, no latency.
// Flow control is carried by cpu_ready, tx_valid/tx_ready, rx_valid/rx_ready and dbg_req/dbg_ack.
interface bf_bus_ctrl_if #(
  parameter int DATA_ADDR_WIDTH = 8
);
  logic [DATA_ADDR_WIDTH-1:0] cpu_addr;
  logic [7:0]                 cpu_wdata;
  logic [7:0]                 cpu_rdata;
  logic                       cpu_rd;
  logic                       cpu_wr;
  logic                       cpu_mreq;
  logic                       cpu_ioreq;
  logic                       cpu_ready;
  logic                       ram_en;
  logic                       ram_we;
  logic [DATA_ADDR_WIDTH-1:0] ram_addr;
  logic [7:0]                 ram_wdata;
  logic [7:0]                 ram_rdata;
  logic [7:0]                 tx_data;
  logic                       tx_valid;
  logic                       tx_ready;
  logic [7:0]                 rx_data;
  logic                       rx_valid;
  logic                       rx_ready;
  logic                       dbg_req;
  logic                       dbg_we;
  logic [DATA_ADDR_WIDTH-1:0] dbg_addr;
  logic [7:0]                 dbg_wdata;
  logic [7:0]                 dbg_rdata;
  logic                       dbg_ack;
  logic                       err_o;

  // Controller side
  modport slave (
    input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr, cpu_mreq, cpu_ioreq,
    input  ram_rdata, tx_ready, rx_data, rx_valid,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output cpu_rdata, cpu_ready, ram_en, ram_we, ram_addr, ram_wdata,
    output tx_data, tx_valid, rx_ready, dbg_rdata, dbg_ack, err_o
  );

  // CPU / RAM / stream / debug environment side
  modport master (
    output cpu_addr, cpu_wdata, cpu_rd, cpu_wr, cpu_mreq, cpu_ioreq,
    output ram_rdata, tx_ready, rx_data, rx_valid,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  cpu_rdata, cpu_ready, ram_en, ram_we, ram_addr, ram_wdata,
    input  tx_data, tx_valid, rx_ready, dbg_rdata, dbg_ack, err_o
  );
endinterface

// File: rtl/bf_bus_ctrl.sv
// Data-side bus controller: decodes CPU strobes to RAM/TX/RX, arbitrates RAM between CPU and debug.
// Latency: RAM access 2 cycles (request + ACK); IO 2 cycles plus cycles waiting in IO_TX/IO_RX.
// Backpressure: IO states hold until tx_ready/rx_valid; BF_BUS_IO_TIMEOUT_EN bounds that wait.
module bf_bus_ctrl #(
  parameter int DATA_ADDR_WIDTH = 8,
  parameter int IO_TIMEOUT      = 1023
) (
  input  logic         clk,
  input  logic         rst,
  bf_bus_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACK, IO_TX, IO_RX} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_RAM, SRC_IO} src_t;

  localparam logic CPU_LAST = 1'b0;
  localparam logic DBG_LAST = 1'b1;

  state_t                     state_q, state_d;
  src_t                       ack_src_q;
  logic                       ack_dbg_q;
  logic                       last_q;
  logic                       err_q;
  logic [7:0]                 io_q;
  logic                       cpu_any;
  logic                       cpu_valid;
  logic                       grant_cpu;
  logic                       grant_dbg;
  logic                       tmo_hit;
  logic                       tmo_fire;
  logic [DATA_ADDR_WIDTH-1:0] ram_addr_c;

  if (IO_TIMEOUT < 1) begin : g_bad_io_timeout
    $error("IO_TIMEOUT must be at least 1");
  end

  // Any raised strobe is a request; only one-hot space plus one-hot direction is well formed.
  assign cpu_any   = bus.cpu_mreq | bus.cpu_ioreq | bus.cpu_rd | bus.cpu_wr;
  assign cpu_valid = (bus.cpu_mreq ^ bus.cpu_ioreq) & (bus.cpu_rd ^ bus.cpu_wr);

  assign bus.ram_addr = ram_addr_c;
  assign bus.err_o    = err_q;

`ifdef BF_BUS_IO_TIMEOUT_EN
  localparam int TMO_W = $clog2(IO_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_q;

  // Count cycles spent waiting in an IO state; cleared whenever outside them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q == IO_TX || state_q == IO_RX) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  assign tmo_hit = (state_q == IO_TX || state_q == IO_RX) &&
                   (tmo_cnt_q == TMO_W'(IO_TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, arbitration and all bus outputs.
  always_comb begin
    state_d       = state_q;
    grant_cpu     = 1'b0;
    grant_dbg     = 1'b0;
    tmo_fire      = 1'b0;
    bus.cpu_rdata = 8'h00;
    bus.cpu_ready = 1'b0;
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    ram_addr_c    = '0;
    bus.ram_wdata = 8'h00;
    bus.tx_data   = 8'h00;
    bus.tx_valid  = 1'b0;
    bus.rx_ready  = 1'b0;
    bus.dbg_rdata = 8'h00;
    bus.dbg_ack   = 1'b0;

    case (state_q)
      IDLE: begin
        // On contention the side that was not served last wins.
        if (cpu_any && (!bus.dbg_req || last_q == DBG_LAST)) begin
          grant_cpu = 1'b1;
        end else if (bus.dbg_req) begin
          grant_dbg = 1'b1;
        end

        if (grant_cpu) begin
          if (!cpu_valid) begin
            state_d = ACK;
          end else if (bus.cpu_mreq) begin
            bus.ram_en    = 1'b1;
            bus.ram_we    = bus.cpu_wr;
            ram_addr_c    = bus.cpu_addr;
            bus.ram_wdata = bus.cpu_wdata;
            state_d       = ACK;
          end else if (bus.cpu_wr) begin
            state_d = IO_TX;
          end else begin
            state_d = IO_RX;
          end
        end else if (grant_dbg) begin
          bus.ram_en    = 1'b1;
          bus.ram_we    = bus.dbg_we;
          ram_addr_c    = bus.dbg_addr;
          bus.ram_wdata = bus.dbg_wdata;
          state_d       = ACK;
        end
      end

      IO_TX: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = bus.cpu_wdata;
        if (bus.tx_ready) begin
          state_d = ACK;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_d  = ACK;
        end
      end

      IO_RX: begin
        bus.rx_ready = 1'b1;
        if (bus.rx_valid) begin
          state_d = ACK;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_d  = ACK;
        end
      end

      ACK: begin
        // Strobes are still held here; they are not looked at until the next IDLE.
        if (ack_dbg_q) begin
          bus.dbg_ack   = 1'b1;
          bus.dbg_rdata = bus.ram_rdata;
        end else begin
          bus.cpu_ready = 1'b1;
          case (ack_src_q)
            SRC_RAM: bus.cpu_rdata = bus.ram_rdata;
            SRC_IO:  bus.cpu_rdata = io_q;
            default: bus.cpu_rdata = 8'h00;
          endcase
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Grant history, ACK tagging, RX capture and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q    <= DBG_LAST;
      ack_dbg_q <= 1'b0;
      ack_src_q <= SRC_NONE;
      io_q      <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      if (grant_cpu) begin
        last_q    <= CPU_LAST;
        ack_dbg_q <= 1'b0;
        if (cpu_valid && bus.cpu_rd) begin
          ack_src_q <= bus.cpu_mreq ? SRC_RAM : SRC_IO;
        end else begin
          ack_src_q <= SRC_NONE;
        end
      end else if (grant_dbg) begin
        last_q    <= DBG_LAST;
        ack_dbg_q <= 1'b1;
        ack_src_q <= SRC_NONE;
      end

      if (state_q == IO_RX && bus.rx_valid) begin
        io_q <= bus.rx_data;
      end else if (state_q == IO_RX && tmo_fire) begin
        io_q <= 8'h00;
      end

      if ((grant_cpu && !cpu_valid) || tmo_fire) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bf_bus_ctrl.sv
// Self-checking bench for bf_bus_ctrl with a behavioural synchronous RAM and stream partners.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected CPU completions and grant order are queued at stimulus time and popped on each ack.
module tb_bf_bus_ctrl;
  localparam int AW = 8;
  localparam byte G_CPU = 8'd1;
  localparam byte G_DBG = 8'd2;

  typedef struct {
    logic [7:0] rdata;
    bit         chk_data;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bf_bus_ctrl_if #(.DATA_ADDR_WIDTH(AW)) bus ();

  bf_bus_ctrl #(.DATA_ADDR_WIDTH(AW), .IO_TIMEOUT(1023)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t cpu_q[$];
  byte  grant_q[$];

  logic [7:0] mem [256];
  int         wr_cnt [256];
  int         ram_acc = 0;
  int         tx_hs   = 0;
  int         rx_hs   = 0;
  int         cyc     = 0;

  // Synchronous RAM model plus handshake monitors.
  always @(posedge clk) begin
    cyc++;
    if (bus.ram_en) begin
      ram_acc++;
      if (bus.ram_we) begin
        mem[bus.ram_addr] = bus.ram_wdata;
        wr_cnt[bus.ram_addr]++;
      end else begin
        bus.ram_rdata <= mem[bus.ram_addr];
      end
    end
    if (bus.tx_valid && bus.tx_ready) tx_hs++;
    if (bus.rx_valid && bus.rx_ready) rx_hs++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cpu_drive(input logic m, input logic io, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [7:0] wd);
    bus.cpu_mreq  = m;
    bus.cpu_ioreq = io;
    bus.cpu_rd    = r;
    bus.cpu_wr    = w;
    bus.cpu_addr  = a;
    bus.cpu_wdata = wd;
  endtask

  task automatic cpu_idle();
    cpu_drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 8'h00);
  endtask

  // Drive a CPU request and wait (bounded) for cpu_ready; returns on the next edge + 1.
  task automatic cpu_op(input logic m, input logic io, input logic r, input logic w,
                        input logic [AW-1:0] a, input logic [7:0] wd,
                        output int lat, output logic [7:0] got, output bit seen);
    cpu_drive(m, io, r, w, a, wd);
    lat  = 0;
    got  = 8'h00;
    seen = 1'b0;
    while (!seen && lat < 50) begin
      @(negedge clk);
      lat++;
      if (bus.cpu_ready === 1'b1) begin
        seen = 1'b1;
        got  = bus.cpu_rdata;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_op(input logic we, input logic [AW-1:0] a, input logic [7:0] wd,
                        output bit seen, output logic [7:0] got);
    int n;
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = we;
    bus.dbg_addr  = a;
    bus.dbg_wdata = wd;
    seen = 1'b0;
    got  = 8'h00;
    n    = 0;
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      if (bus.dbg_ack === 1'b1) begin
        seen = 1'b1;
        got  = bus.dbg_rdata;
      end
    end
    @(posedge clk);
    #1;
    bus.dbg_req = 1'b0;
    bus.dbg_we  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({bus.cpu_ready, bus.dbg_ack, bus.ram_en, bus.tx_valid, bus.rx_ready} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 00000",
               {bus.cpu_ready, bus.dbg_ack, bus.ram_en, bus.tx_valid, bus.rx_ready});
    end
    n_tests++;
    if (bus.err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: got %b expected 0", bus.err_o);
    end
    n_tests++;
    if (bus.cpu_rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h expected 00", bus.cpu_rdata);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus.cpu_ready, bus.dbg_ack, bus.ram_en, bus.err_o} !== 4'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b expected 0000",
               {bus.cpu_ready, bus.dbg_ack, bus.ram_en, bus.err_o});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ram_sweep();
    int lat, t0, bad, total;
    logic [7:0] got;
    bit seen;
    exp_t e;
    t0 = cyc;
    for (int a = 0; a < 256; a++) begin
      cpu_q.push_back('{rdata: 8'h00, chk_data: 1'b0, lat: 2});
      cpu_op(1'b1, 1'b0, 1'b0, 1'b1, AW'(a), 8'h00, lat, got, seen);
      e = cpu_q.pop_front();
      n_tests++;
      if (!seen || lat !== e.lat) begin
        n_fail++;
        $display("FAIL sweep_latency addr %0d: got %0d (seen %0b) expected %0d", a, lat, seen, e.lat);
      end
    end
    n_tests++;
    if (cyc - t0 !== 512) begin
      n_fail++;
      $display("FAIL sweep_cycles: got %0d expected 512", cyc - t0);
    end
    cpu_idle();
    bad   = 0;
    total = 0;
    for (int a = 0; a < 256; a++) begin
      total += wr_cnt[a];
      if (wr_cnt[a] != 1 || mem[a] !== 8'h00) bad++;
    end
    n_tests++;
    if (total !== 256) begin
      n_fail++;
      $display("FAIL sweep_write_total: got %0d expected 256", total);
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL sweep_per_addr: got %0d bad addresses expected 0", bad);
    end
  endtask

  task automatic test_mem_read();
    int lat;
    logic [7:0] got;
    bit seen;
    exp_t e;
    dbg_op(1'b1, 8'h10, 8'h5A, seen, got);
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL dbg_write_ack: got no ack expected ack");
    end
    cpu_q.push_back('{rdata: 8'h5A, chk_data: 1'b1, lat: 2});
    cpu_op(1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00, lat, got, seen);
    cpu_idle();
    e = cpu_q.pop_front();
    n_tests++;
    if (!seen || lat !== e.lat) begin
      n_fail++;
      $display("FAIL mem_read_latency: got %0d expected %0d", lat, e.lat);
    end
    n_tests++;
    if (got !== e.rdata) begin
      n_fail++;
      $display("FAIL mem_read_data: got %h expected %h", got, e.rdata);
    end
    dbg_op(1'b0, 8'h10, 8'h00, seen, got);
    n_tests++;
    if (!seen || got !== 8'h5A) begin
      n_fail++;
      $display("FAIL dbg_read_data: got %h (seen %0b) expected 5a", got, seen);
    end
  endtask

  task automatic test_io_write();
    int i, nvalid, baddata, hs0;
    bit seen;
    exp_t e;
    hs0 = tx_hs;
    cpu_q.push_back('{rdata: 8'h00, chk_data: 1'b0, lat: 2 + 6});
    bus.tx_ready = 1'b0;
    cpu_drive(1'b0, 1'b1, 1'b0, 1'b1, '0, 8'h41);
    i = 0; nvalid = 0; baddata = 0; seen = 1'b0;
    while (!seen && i < 50) begin
      @(negedge clk);
      i++;
      if (bus.tx_valid === 1'b1) begin
        nvalid++;
        if (bus.tx_data !== 8'h41) baddata++;
      end
      if (bus.cpu_ready === 1'b1) seen = 1'b1;
      @(posedge clk);
      #1;
      // Five valid-but-not-ready cycles, then the sink accepts.
      bus.tx_ready = (i >= 6);
    end
    bus.tx_ready = 1'b0;
    cpu_idle();
    e = cpu_q.pop_front();
    n_tests++;
    if (!seen || i !== e.lat) begin
      n_fail++;
      $display("FAIL io_write_latency: got %0d expected %0d", i, e.lat);
    end
    n_tests++;
    if (nvalid !== 6 || baddata !== 0) begin
      n_fail++;
      $display("FAIL io_write_valid: got %0d valid cycles, %0d bad bytes expected 6, 0", nvalid, baddata);
    end
    n_tests++;
    if (tx_hs - hs0 !== 1) begin
      n_fail++;
      $display("FAIL io_write_handshakes: got %0d expected 1", tx_hs - hs0);
    end
  endtask

  task automatic test_io_read();
    int i, nrdy, hs0;
    bit seen;
    logic [7:0] got;
    exp_t e;
    hs0 = rx_hs;
    cpu_q.push_back('{rdata: 8'h7E, chk_data: 1'b1, lat: 5});
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h7E;
    cpu_drive(1'b0, 1'b1, 1'b1, 1'b0, '0, 8'h00);
    i = 0; nrdy = 0; seen = 1'b0; got = 8'h00;
    while (!seen && i < 50) begin
      @(negedge clk);
      i++;
      if (bus.rx_ready === 1'b1) nrdy++;
      if (bus.cpu_ready === 1'b1) begin
        seen = 1'b1;
        got  = bus.cpu_rdata;
      end
      @(posedge clk);
      #1;
      bus.rx_valid = (i >= 3) && !seen;
    end
    bus.rx_valid = 1'b0;
    cpu_idle();
    e = cpu_q.pop_front();
    n_tests++;
    if (!seen || i !== e.lat) begin
      n_fail++;
      $display("FAIL io_read_latency: got %0d expected %0d", i, e.lat);
    end
    n_tests++;
    if (got !== e.rdata) begin
      n_fail++;
      $display("FAIL io_read_data: got %h expected %h", got, e.rdata);
    end
    n_tests++;
    if (nrdy !== 3 || rx_hs - hs0 !== 1) begin
      n_fail++;
      $display("FAIL io_read_ready: got %0d ready cycles, %0d handshakes expected 3, 1", nrdy, rx_hs - hs0);
    end
  endtask

  task automatic test_arbitration();
    byte g;
    int  both;
    do_reset();
    grant_q = '{G_CPU, G_DBG, G_CPU, G_DBG};
    both = 0;
    bus.dbg_req  = 1'b1;
    bus.dbg_we   = 1'b0;
    bus.dbg_addr = 8'h20;
    cpu_drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.cpu_ready === 1'b1 && bus.dbg_ack === 1'b1) both++;
      if (bus.cpu_ready === 1'b1 || bus.dbg_ack === 1'b1) begin
        g = (bus.cpu_ready === 1'b1) ? G_CPU : G_DBG;
        n_tests++;
        if (grant_q.size() == 0) begin
          n_fail++;
          $display("FAIL arb_extra_grant: got grant %0d expected none", g);
        end else if (g !== grant_q[0]) begin
          n_fail++;
          $display("FAIL arb_order cycle %0d: got %0d expected %0d", c, g, grant_q[0]);
          void'(grant_q.pop_front());
        end else begin
          void'(grant_q.pop_front());
        end
        n_tests++;
        if ((g == G_CPU && bus.cpu_rdata !== 8'h5A) || (g == G_DBG && bus.dbg_rdata !== 8'h00)) begin
          n_fail++;
          $display("FAIL arb_rdata cycle %0d: got cpu %h dbg %h expected cpu 5a dbg 00",
                   c, bus.cpu_rdata, bus.dbg_rdata);
        end
      end
    end
    @(posedge clk);
    #1;
    bus.dbg_req = 1'b0;
    cpu_idle();
    n_tests++;
    if (grant_q.size() !== 0 || both !== 0) begin
      n_fail++;
      $display("FAIL arb_complete: got %0d missing grants, %0d double acks expected 0, 0", grant_q.size(), both);
    end
    n_tests++;
    if (bus.err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL arb_err: got %b expected 0", bus.err_o);
    end
  endtask

  task automatic test_malformed();
    logic [3:0] pats [3];
    int ram0, tx0, rx0, lat;
    logic [7:0] got;
    bit seen;
    exp_t e;
    pats[0] = 4'b1011;  // mreq, rd and wr
    pats[1] = 4'b1110;  // mreq and ioreq, rd
    pats[2] = 4'b0001;  // wr with no space strobe
    ram0 = ram_acc; tx0 = tx_hs; rx0 = rx_hs;
    for (int p = 0; p < 3; p++) begin
      cpu_q.push_back('{rdata: 8'h00, chk_data: 1'b0, lat: 2});
      cpu_op(pats[p][3], pats[p][2], pats[p][1], pats[p][0], 8'h10, 8'hC3, lat, got, seen);
      cpu_idle();
      @(posedge clk);
      #1;
      e = cpu_q.pop_front();
      n_tests++;
      if (!seen || lat !== e.lat) begin
        n_fail++;
        $display("FAIL malformed_ready pat %b: got %0d (seen %0b) expected %0d", pats[p], lat, seen, e.lat);
      end
    end
    n_tests++;
    if (ram_acc !== ram0 || tx_hs !== tx0 || rx_hs !== rx0) begin
      n_fail++;
      $display("FAIL malformed_side_effects: got ram %0d tx %0d rx %0d expected 0 0 0",
               ram_acc - ram0, tx_hs - tx0, rx_hs - rx0);
    end
    n_tests++;
    if (bus.err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL malformed_err: got %b expected 1", bus.err_o);
    end
    cpu_q.push_back('{rdata: 8'h5A, chk_data: 1'b1, lat: 2});
    cpu_op(1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00, lat, got, seen);
    cpu_idle();
    e = cpu_q.pop_front();
    n_tests++;
    if (!seen || got !== e.rdata || bus.err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got data %h err %b expected data %h err 1", got, bus.err_o, e.rdata);
    end
  endtask

  task automatic test_reset_mid_rx();
    int acks, hs0;
    do_reset();
    n_tests++;
    if (bus.err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clears_err: got %b expected 0", bus.err_o);
    end
    hs0 = rx_hs;
    bus.rx_valid = 1'b0;
    cpu_drive(1'b0, 1'b1, 1'b1, 1'b0, '0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (bus.rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rx_wait_ready: got %b expected 1", bus.rx_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.rx_ready !== 1'b0 || bus.cpu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_rx: got rx_ready %b cpu_ready %b expected 0 0", bus.rx_ready, bus.cpu_ready);
    end
    cpu_idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.cpu_ready === 1'b1 || bus.rx_ready === 1'b1) acks++;
    end
    n_tests++;
    if (acks !== 0 || rx_hs !== hs0) begin
      n_fail++;
      $display("FAIL reset_abandon: got %0d ack/ready cycles %0d handshakes expected 0 0", acks, rx_hs - hs0);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      mem[a]    = 8'hFF;
      wr_cnt[a] = 0;
    end
    cpu_idle();
    bus.ram_rdata = 8'h00;
    bus.tx_ready  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.dbg_req   = 1'b0;
    bus.dbg_we    = 1'b0;
    bus.dbg_addr  = '0;
    bus.dbg_wdata = 8'h00;

    test_reset();
    test_ram_sweep();
    test_mem_read();
    test_io_write();
    test_io_read();
    test_arbitration();
    test_malformed();
    test_reset_mid_rx();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
